vga_timing_pattern: RTL and testbench

VGA_TIMING_PATTERN -- requirements
Module: vga_timing_pattern

---
 rtl/vga_timing_pattern.sv | 205 ++++++++++++++++++++
 tb/tb_vga_timing_pattern.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pattern.sv
// -----------------------------------------------------------------------------
// vga_timing_pattern
//
// Raster timing generator with a built-in test-pattern source. Two counters
// (hc across a line, vc down the frame) walk the full raster including the
// blanking intervals; every output is registered from the counter values of
// the current cycle, so all outputs lag the counters by exactly one clock and
// stay aligned with each other.
//
// Parameters
//   VIDEO_WIDTH        bits per colour channel
//   ACTIVE_COLS/ROWS   visible pixels per line / visible lines per frame
//   H_FP/H_SYNC/H_BP   horizontal front porch, sync, back porch (pixels)
//   V_FP/V_SYNC/V_BP   vertical front porch, sync, back porch (lines)
//   SYNC_ACTIVE_LOW    1: sync pulses are driven low, 0: driven high
//   CNT_W              width of the col/row counters
//
// Ports
//   clock              pixel clock
//   reset_n            synchronous active-low reset
//   enable             counters advance while high; outputs blank while low
//   mode[2:0]          pattern select, taken only at the end of a frame
//   hsync, vsync       sync pulses, polarity set by SYNC_ACTIVE_LOW
//   active             high while the registered pixel is visible
//   col, row           registered pixel position (also during blanking)
//   frame_start        one-cycle pulse at pixel (0,0)
//   redv, grnv, bluv   colour data, zero outside the visible area
// -----------------------------------------------------------------------------
module vga_timing_pattern #(
    parameter int VIDEO_WIDTH     = 3,
    parameter int ACTIVE_COLS     = 640,
    parameter int ACTIVE_ROWS     = 480,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CNT_W           = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [2:0]             mode,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   active,
    output logic [CNT_W-1:0]       col,
    output logic [CNT_W-1:0]       row,
    output logic                   frame_start,
    output logic [VIDEO_WIDTH-1:0] redv,
    output logic [VIDEO_WIDTH-1:0] grnv,
    output logic [VIDEO_WIDTH-1:0] bluv
);

    localparam int TOTAL_COLS = ACTIVE_COLS + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FP + V_SYNC + V_BP;
    localparam int RAMP_W     = CNT_W + VIDEO_WIDTH;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] H_EDGE   = CNT_W'(ACTIVE_COLS - 1);
    localparam logic [CNT_W-1:0] V_EDGE   = CNT_W'(ACTIVE_ROWS - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(ACTIVE_COLS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(ACTIVE_COLS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(ACTIVE_ROWS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(ACTIVE_ROWS + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] BAR_W    = CNT_W'(ACTIVE_COLS / 8);
    localparam logic [RAMP_W-1:0] RAMP_DIV = RAMP_W'(ACTIVE_COLS);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [VIDEO_WIDTH-1:0] MAX = {VIDEO_WIDTH{1'b1}};

    // Codes 6 and 7 have no name and fall through to black.
    typedef enum logic [2:0] {
        PAT_BLACK   = 3'd0,
        PAT_WHITE   = 3'd1,
        PAT_BARS    = 3'd2,
        PAT_CHECKER = 3'd3,
        PAT_BORDER  = 3'd4,
        PAT_RAMP    = 3'd5
    } pattern_e;

    logic [CNT_W-1:0]       hc;
    logic [CNT_W-1:0]       vc;
    pattern_e               mode_q;

    logic                   h_last;
    logic                   v_last;
    logic                   visible;
    logic                   hs_on;
    logic                   vs_on;
    logic [2:0]             bar_idx;
    logic [VIDEO_WIDTH-1:0] ramp_lvl;
    logic [VIDEO_WIDTH-1:0] pat_r;
    logic [VIDEO_WIDTH-1:0] pat_g;
    logic [VIDEO_WIDTH-1:0] pat_b;

    assign h_last  = (hc == H_LAST);
    assign v_last  = (vc == V_LAST);
    assign visible = (hc < H_ACT) && (vc < V_ACT);
    assign hs_on   = (hc >= HS_START) && (hc <= HS_END);
    assign vs_on   = (vc >= VS_START) && (vc <= VS_END);

    // Divisors are elaboration-time constants, so these reduce to fixed logic.
    assign bar_idx  = 3'(hc / BAR_W);
    assign ramp_lvl = VIDEO_WIDTH'({hc, {VIDEO_WIDTH{1'b0}}} / RAMP_DIV);

    // Raster counters. mode is sampled only on the very last pixel of the
    // frame so a pattern change never takes effect part-way down the screen.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            hc     <= '0;
            vc     <= '0;
            mode_q <= PAT_BLACK;
        end else if (enable) begin
            if (h_last) begin
                hc <= '0;
                if (v_last) begin
                    vc     <= '0;
                    mode_q <= pattern_e'(mode);
                end else begin
                    vc <= vc + 1'b1;
                end
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // Pattern generator, evaluated on the current counter values.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case leaves a value unassigned (no latch).
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_q)
            PAT_WHITE: begin
                pat_r = MAX;
                pat_g = MAX;
                pat_b = MAX;
            end
            PAT_BARS: begin
                pat_r = bar_idx[2] ? MAX : '0;
                pat_g = bar_idx[1] ? MAX : '0;
                pat_b = bar_idx[0] ? MAX : '0;
            end
            PAT_CHECKER: begin
                if (hc[5] ^ vc[5]) begin
                    pat_r = MAX;
                    pat_g = MAX;
                    pat_b = MAX;
                end
            end
            PAT_BORDER: begin
                if (hc == '0 || hc == H_EDGE || vc == '0 || vc == V_EDGE) begin
                    pat_r = MAX;
                    pat_g = MAX;
                    pat_b = MAX;
                end
            end
            PAT_RAMP: begin
                pat_r = ramp_lvl;
                pat_g = ramp_lvl;
                pat_b = ramp_lvl;
            end
            default: ;
        endcase
    end

    // Output stage: one register per output, all loaded on the same edge from
    // the same counter snapshot. While enable is low the position still
    // reflects the held counters but everything else is blanked.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            active      <= 1'b0;
            col         <= '0;
            row         <= '0;
            frame_start <= 1'b0;
            redv        <= '0;
            grnv        <= '0;
            bluv        <= '0;
        end else begin
            hsync       <= (enable && hs_on) ? SYNC_ON : SYNC_OFF;
            vsync       <= (enable && vs_on) ? SYNC_ON : SYNC_OFF;
            active      <= enable && visible;
            col         <= hc;
            row         <= vc;
            frame_start <= enable && (hc == '0) && (vc == '0);
            redv        <= (enable && visible) ? pat_r : '0;
            grnv        <= (enable && visible) ? pat_g : '0;
            bluv        <= (enable && visible) ? pat_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_pattern
//
// Four instances of vga_timing_pattern share one clock:
//   u_def  default geometry: reset state, first frame_start, hsync placement
//   u_mid  default line timing, 3 visible rows: frame period, vsync, pattern
//          table, mode change at frame boundary, enable hold, reset pulse
//   u_tny  tiny raster driven randomly and compared every cycle against a
//          model based on a linear pixel index
//   u_wid  active-high sync, 1056-pixel line
// -----------------------------------------------------------------------------
module tb_vga_timing_pattern;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- default instance ----------------
    logic       rst_d, en_d;
    logic [2:0] mode_d;
    logic       hs_d, vs_d, act_d, fs_d;
    logic [9:0] col_d, row_d;
    logic [2:0] r_d, g_d, b_d;

    vga_timing_pattern u_def (
        .clock(clock), .reset_n(rst_d), .enable(en_d), .mode(mode_d),
        .hsync(hs_d), .vsync(vs_d), .active(act_d), .col(col_d), .row(row_d),
        .frame_start(fs_d), .redv(r_d), .grnv(g_d), .bluv(b_d)
    );

    // ---------------- short-frame instance (800 x 6 lines) ----------------
    logic       rst_m, en_m;
    logic [2:0] mode_m;
    logic       hs_m, vs_m, act_m, fs_m;
    logic [9:0] col_m, row_m;
    logic [2:0] r_m, g_m, b_m;

    vga_timing_pattern #(.ACTIVE_ROWS(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_mid (
        .clock(clock), .reset_n(rst_m), .enable(en_m), .mode(mode_m),
        .hsync(hs_m), .vsync(vs_m), .active(act_m), .col(col_m), .row(row_m),
        .frame_start(fs_m), .redv(r_m), .grnv(g_m), .bluv(b_m)
    );

    // ---------------- tiny instance (80 x 37) ----------------
    logic       rst_t, en_t;
    logic [2:0] mode_t;
    logic       hs_t, vs_t, act_t, fs_t;
    logic [9:0] col_t, row_t;
    logic [2:0] r_t, g_t, b_t;

    vga_timing_pattern #(
        .ACTIVE_COLS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .ACTIVE_ROWS(34), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_tny (
        .clock(clock), .reset_n(rst_t), .enable(en_t), .mode(mode_t),
        .hsync(hs_t), .vsync(vs_t), .active(act_t), .col(col_t), .row(row_t),
        .frame_start(fs_t), .redv(r_t), .grnv(g_t), .bluv(b_t)
    );

    // ---------------- wide, active-high sync instance ----------------
    logic        rst_w, en_w;
    logic [2:0]  mode_w;
    logic        hs_w, vs_w, act_w, fs_w;
    logic [10:0] col_w, row_w;
    logic [2:0]  r_w, g_w, b_w;

    vga_timing_pattern #(
        .SYNC_ACTIVE_LOW(0), .ACTIVE_COLS(800), .H_FP(40), .H_SYNC(128),
        .H_BP(88), .CNT_W(11)
    ) u_wid (
        .clock(clock), .reset_n(rst_w), .enable(en_w), .mode(mode_w),
        .hsync(hs_w), .vsync(vs_w), .active(act_w), .col(col_w), .row(row_w),
        .frame_start(fs_w), .redv(r_w), .grnv(g_w), .bluv(b_w)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid_goto(input int r, input int c);
        int n = 0;
        while (!(row_m == 10'(r) && col_m == 10'(c)) && n < 6000) begin
            tick();
            n++;
        end
        check($sformatf("mid reach r%0d c%0d", r, c), {row_m, col_m}, {10'(r), 10'(c)});
    endtask

    task automatic mid_wait_fs(output int cycles, output int vs_low,
                               output int vs_row, output int video_nz);
        cycles   = 0;
        vs_low   = 0;
        vs_row   = -1;
        video_nz = 0;
        do begin
            tick();
            cycles++;
            if (vs_m == 1'b0) begin
                vs_low++;
                if (vs_row < 0) vs_row = int'(row_m);
            end
            if ({r_m, g_m, b_m} != 9'd0) video_nz++;
        end while (fs_m !== 1'b1 && cycles < 6000);
        check("mid frame_start seen", fs_m, 1'b1);
    endtask

    // ---------------- pattern table for u_mid ----------------
    typedef struct {
        int         mode;
        int         row;
        int         col;
        logic [8:0] rgb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int m, input int r, input int c, input logic [8:0] rgb);
        vec_t v;
        v.mode = m;
        v.row  = r;
        v.col  = c;
        v.rgb  = rgb;
        return v;
    endfunction

    // ---------------- reference model for u_tny ----------------
    localparam int T_AC  = 64;
    localparam int T_TC  = 80;
    localparam int T_AR  = 34;
    localparam int T_TR  = 37;
    localparam int T_TOT = T_TC * T_TR;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [9:0] col;
        logic [9:0] row;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } out_t;

    // Expected outputs for linear pixel index p, latched pattern mq, enable en.
    function automatic out_t tiny_expect(input int p, input int mq, input bit en);
        out_t o;
        int   hc, vc, k, lvl;
        bit   vis;
        hc  = p % T_TC;
        vc  = p / T_TC;
        vis = (hc < T_AC) && (vc < T_AR);
        o     = '0;
        o.hs  = (en && hc >= T_AC + 4 && hc < T_AC + 12) ? 1'b0 : 1'b1;
        o.vs  = (en && vc == T_AR + 1) ? 1'b0 : 1'b1;
        o.act = en && vis;
        o.fs  = en && (p == 0);
        o.col = 10'(hc);
        o.row = 10'(vc);
        lvl   = 0;
        if (en && vis) begin
            case (mq)
                1: lvl = 7;
                2: begin
                    k   = hc / (T_AC / 8);
                    o.r = ((k / 4) % 2 == 1) ? 3'd7 : 3'd0;
                    o.g = ((k / 2) % 2 == 1) ? 3'd7 : 3'd0;
                    o.b = (k % 2 == 1) ? 3'd7 : 3'd0;
                end
                3: lvl = (((hc / 32) + (vc / 32)) % 2 == 1) ? 7 : 0;
                4: lvl = (hc == 0 || hc == T_AC - 1 || vc == 0 || vc == T_AR - 1) ? 7 : 0;
                5: lvl = (hc * 8) / T_AC;
                default: lvl = 0;
            endcase
            if (mq != 2) begin
                o.r = 3'(lvl);
                o.g = 3'(lvl);
                o.b = 3'(lvl);
            end
        end
        return o;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int cyc, vsl, vsr, vnz, cur_mode;
        int low_cnt, first_low, last_low, pos_err, act_err, vs_err, fs_cnt, hold_err;
        int hi_cnt, first_hi, last_hi, max_col;
        int p, mq;
        out_t exp_o, got_o;

        rst_d = 1'b0; en_d = 1'b1; mode_d = 3'd0;
        rst_m = 1'b0; en_m = 1'b1; mode_m = 3'd2;
        rst_t = 1'b0; en_t = 1'b1; mode_t = 3'd0;
        rst_w = 1'b0; en_w = 1'b1; mode_w = 3'd0;

        // ======== default geometry ========
        tick();
        check("def reset state", {hs_d, vs_d, act_d, fs_d, col_d, row_d, r_d, g_d, b_d},
              {1'b1, 1'b1, 1'b0, 1'b0, 20'd0, 9'd0});
        rst_d = 1'b1;
        tick();
        check("def first cycle fs", {fs_d, act_d, col_d, row_d}, {1'b1, 1'b1, 20'd0});

        low_cnt = 0; first_low = -1; last_low = -1;
        pos_err = 0; act_err = 0; vs_err = 0; fs_cnt = 0;
        for (int c = 1; c < 1600; c++) begin
            tick();
            if (int'(col_d) != c % 800 || int'(row_d) != c / 800) pos_err++;
            if (act_d != ((c % 800) < 640)) act_err++;
            if (vs_d != 1'b1) vs_err++;
            if (fs_d) fs_cnt++;
            if (hs_d == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = int'(col_d);
                if (row_d == 10'd0) last_low = int'(col_d);
            end
        end
        check("def hsync low clocks (2 lines)", low_cnt, 192);
        check("def hsync first col", first_low, 656);
        check("def hsync last col", last_low, 751);
        check("def col/row tracking errors", pos_err, 0);
        check("def active errors", act_err, 0);
        check("def vsync idle errors", vs_err, 0);
        check("def stray frame_start", fs_cnt, 0);
        rst_d = 1'b0;

        // ======== short frame: period and vsync ========
        tick();
        check("mid reset state", {hs_m, vs_m, fs_m, col_m, row_m}, {1'b1, 1'b1, 1'b0, 20'd0});
        rst_m = 1'b1;
        tick();
        check("mid first fs", fs_m, 1'b1);
        mid_wait_fs(cyc, vsl, vsr, vnz);
        check("mid frame period", cyc, 4800);
        check("mid vsync low clocks", vsl, 800);
        check("mid vsync first row", vsr, 4);
        check("mid mode0 video nonzero", vnz, 0);

        // ======== pattern table ========
        tbl.push_back(mk(2, 0,   0, 9'o000));
        tbl.push_back(mk(2, 0,  79, 9'o000));
        tbl.push_back(mk(2, 0,  80, 9'o007));
        tbl.push_back(mk(2, 0, 159, 9'o007));
        tbl.push_back(mk(2, 0, 160, 9'o070));
        tbl.push_back(mk(2, 0, 240, 9'o077));
        tbl.push_back(mk(2, 0, 320, 9'o700));
        tbl.push_back(mk(2, 0, 400, 9'o707));
        tbl.push_back(mk(2, 0, 480, 9'o770));
        tbl.push_back(mk(2, 0, 560, 9'o777));
        tbl.push_back(mk(2, 0, 639, 9'o777));
        tbl.push_back(mk(2, 0, 640, 9'o000));
        tbl.push_back(mk(2, 1, 100, 9'o007));
        tbl.push_back(mk(4, 0,   0, 9'o777));
        tbl.push_back(mk(4, 1,   0, 9'o777));
        tbl.push_back(mk(4, 1,   5, 9'o000));
        tbl.push_back(mk(4, 1, 639, 9'o777));
        tbl.push_back(mk(4, 1, 640, 9'o000));
        tbl.push_back(mk(4, 2,   5, 9'o777));
        tbl.push_back(mk(5, 0,   0, 9'o000));
        tbl.push_back(mk(5, 0,  79, 9'o000));
        tbl.push_back(mk(5, 0,  80, 9'o111));
        tbl.push_back(mk(5, 0, 320, 9'o444));
        tbl.push_back(mk(5, 0, 559, 9'o666));
        tbl.push_back(mk(5, 0, 560, 9'o777));
        tbl.push_back(mk(5, 0, 639, 9'o777));
        tbl.push_back(mk(1, 0,  10, 9'o777));
        tbl.push_back(mk(1, 0, 700, 9'o000));
        tbl.push_back(mk(1, 2,  10, 9'o777));
        tbl.push_back(mk(1, 3,  10, 9'o000));
        tbl.push_back(mk(3, 0,   0, 9'o000));
        tbl.push_back(mk(3, 0,  32, 9'o777));
        tbl.push_back(mk(3, 0,  64, 9'o000));
        tbl.push_back(mk(3, 0, 639, 9'o777));

        cur_mode = 2;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].mode != cur_mode) begin
                mode_m = 3'(tbl[i].mode);
                mid_wait_fs(cyc, vsl, vsr, vnz);
                cur_mode = tbl[i].mode;
            end
            mid_goto(tbl[i].row, tbl[i].col);
            check($sformatf("pattern mode%0d r%0d c%0d", tbl[i].mode, tbl[i].row, tbl[i].col),
                  {r_m, g_m, b_m}, tbl[i].rgb);
        end

        // ======== mode change mid-frame: checker holds until wrap ========
        mid_goto(1, 0);
        mode_m = 3'd5;
        mid_goto(1, 32);
        check("checker kept after mode change c32", {r_m, g_m, b_m}, 9'o777);
        mid_goto(1, 600);
        check("checker kept after mode change c600", {r_m, g_m, b_m}, 9'o000);
        mid_wait_fs(cyc, vsl, vsr, vnz);
        check("ramp at new frame c0", {r_m, g_m, b_m}, 9'o000);
        mid_goto(0, 600);
        check("ramp at new frame c600", {r_m, g_m, b_m}, 9'o777);
        mid_goto(0, 639);
        check("ramp at new frame c639", {r_m, g_m, b_m}, 9'o777);

        // ======== enable dropped for 50 cycles at col 300 ========
        mid_wait_fs(cyc, vsl, vsr, vnz);
        for (int i = 0; i < 299; i++) tick();
        check("hold setup col", col_m, 10'd299);
        en_m = 1'b0;
        hold_err = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({col_m, row_m, hs_m, vs_m, act_m, fs_m, r_m, g_m, b_m} !==
                {10'd300, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0}) hold_err++;
        end
        check("hold frozen/blanked errors", hold_err, 0);
        en_m = 1'b1;
        tick();
        check("resume col/active/ramp", {col_m, act_m, r_m}, {10'd300, 1'b1, 3'd3});
        mid_wait_fs(cyc, vsl, vsr, vnz);
        check("frame period with hold", 350 + cyc, 4850);

        // ======== one-cycle reset pulse mid-frame ========
        mid_goto(1, 200);
        rst_m = 1'b0;
        tick();
        check("mid reset pulse state", {col_m, row_m, fs_m, act_m, hs_m, r_m, g_m, b_m},
              {20'd0, 1'b0, 1'b0, 1'b1, 9'd0});
        rst_m = 1'b1;
        tick();
        check("post-reset first cycle", {col_m, row_m, fs_m}, {20'd0, 1'b1});
        mid_goto(0, 600);
        check("post-reset mode cleared", {r_m, g_m, b_m}, 9'o000);
        rst_m = 1'b0;

        // ======== tiny raster, random stimulus against model ========
        p  = 0;
        mq = 0;
        for (int i = 0; i < 18000; i++) begin
            rst_t  = (i == 0) ? 1'b0 : ($urandom_range(0, 3999) != 0);
            en_t   = ($urandom_range(0, 15) != 0);
            mode_t = 3'($urandom_range(0, 7));
            tick();
            if (!rst_t) begin
                exp_o    = '0;
                exp_o.hs = 1'b1;
                exp_o.vs = 1'b1;
                p  = 0;
                mq = 0;
            end else begin
                exp_o = tiny_expect(p, mq, en_t);
                if (en_t) begin
                    if (p == T_TOT - 1) mq = int'(mode_t);
                    p = (p + 1) % T_TOT;
                end
            end
            got_o = {hs_t, vs_t, act_t, fs_t, col_t, row_t, r_t, g_t, b_t};
            check($sformatf("tiny model cycle %0d", i), got_o, exp_o);
        end
        rst_t = 1'b0;

        // ======== wide line, active-high sync ========
        tick();
        check("wide reset sync inactive", {hs_w, vs_w}, 2'b00);
        rst_w = 1'b1;
        hi_cnt = 0; first_hi = -1; last_hi = -1; max_col = 0; vs_err = 0;
        for (int i = 0; i < 2112; i++) begin
            tick();
            if (hs_w) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = int'(col_w);
                if (row_w == 11'd0) last_hi = int'(col_w);
            end
            if (row_w == 11'd0 && int'(col_w) > max_col) max_col = int'(col_w);
            if (vs_w) vs_err++;
        end
        check("wide hsync high clocks (2 lines)", hi_cnt, 256);
        check("wide hsync first col", first_hi, 840);
        check("wide hsync last col", last_hi, 967);
        check("wide last col of line", max_col, 1055);
        check("wide end position", {row_w, col_w}, {11'd1, 11'd1055});
        check("wide vsync idle errors", vs_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
